irq_priority_resolver: RTL and testbench
========================================

# irq_priority_resolver

Parametrised, clocked priority resolver and in-service tracker for the interrupt controller. Takes the pending-request vector and mask, maintains the In-Service Register (ISR), and decides when to raise the interrupt request toward the CPU. On acknowledge it latches the winning channel's index and one-hot code; on End-Of-Interrupt it retires ISR bits, with optional automatic priority rotation. It sits between the request/mask registers and the acknowledge/vector logic, and generalises the fixed 3-to-8 index decoding to any channel count.

## Interface
- CHANNELS, 8, number of interrupt channels (≥2); IDX_W = $clog2(CHANNELS) is derived, not overridable
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- irr  in  CHANNELS  pending requests, level, owned upstream
- imr  in  CHANNELS  mask, 1 = channel masked
- rotate_mode  in  1  1 = automatic rotation on EOI
- ack  in  1  one-cycle acknowledge strobe
- eoi  in  1  one-cycle End-Of-Interrupt strobe
- eoi_specific  in  1  qualifies eoi: 1 = specific, 0 = non-specific
- eoi_level  in  IDX_W  channel targeted by a specific EOI
- int_req  out  1  registered interrupt request to CPU
- ack_vec  out  IDX_W  index of acknowledged channel, held until next ack
- ack_onehot  out  CHANNELS  one-cycle pulse; upstream clears the matching irr bit
- spurious  out  1  one-cycle pulse: ack arrived with no valid candidate
- isr  out  CHANNELS  In-Service Register
- bottom  out  IDX_W  index of current lowest-priority channel

## Operation
- Reset values: isr=0, bottom=CHANNELS-1 (channel 0 highest), int_req=0, ack_vec=0, ack_onehot=0, spurious=0.
- Priority order: (bottom+1) mod CHANNELS highest, then increasing index modulo CHANNELS; bottom is lowest.
- Candidates = irr & ~imr & ~isr. Winner = highest-priority candidate. A winner is valid only if it is strictly higher priority than the highest-priority set ISR bit (fully nested); with isr=0 any winner is valid.
- int_req next = valid winner exists, except forced 0 on any edge that samples ack=1.
- Ack with valid winner w: isr[w] set, ack_vec=w, ack_onehot=1<<w for one cycle.
- Ack with no valid winner: spurious=1 for one cycle, ack_vec=CHANNELS-1, isr and ack_onehot unchanged (ack_onehot=0).
- Non-specific EOI: clears the highest-priority set ISR bit h; if rotate_mode, bottom=h. If isr=0, no change.
- Specific EOI: clears isr[eoi_level] (no-op if already clear); if rotate_mode, bottom=eoi_level, even if the bit was clear. eoi_level ≥ CHANNELS is ignored entirely.
- rotate_mode=0: bottom never changes after reset.
- Simultaneous ack and eoi: both evaluated against pre-edge registered isr and bottom; isr_next = (isr & ~eoi_clear) | ack_set; ack set wins on conflicting bit. Rotation applies from the next cycle.
- Inputs irr/imr are synchronous to clk; no internal synchroniser.

## Timing
- irr/imr change sampled at edge k -> int_req valid after edge k.
- ack sampled at edge k -> isr/ack_vec/ack_onehot/spurious updated after edge k; int_req low after edge k; re-evaluated at edge k+1 with the new isr.
- eoi sampled at edge k -> isr/bottom updated after edge k; int_req reflects the result after edge k+1.
- ack_onehot and spurious are single-cycle pulses regardless of ack held high; back-to-back acks each process a fresh winner.
- Reset assertion mid-operation clears all state immediately (asynchronous); the first evaluation occurs at the first edge after deassertion.

## Test plan
- Reset, irr=8'h24, imr=0 -> int_req=1 next cycle; ack -> ack_vec=2, ack_onehot=8'h04, isr=8'h04, int_req=0 for the ack cycle.
- isr=8'h04, irr raises bit 1 -> int_req=1 (nesting); raise only bit 5 -> int_req stays 0.
- ack with irr=0 -> spurious=1, ack_vec=7, isr unchanged.
- rotate_mode=1, isr=8'h08, non-specific EOI -> isr=0, bottom=3; irr=8'h81 then ack -> ack_vec=7 (channel 4 highest).
- Same-cycle ack (winner 1) and specific EOI level 3 with isr=8'h08 -> isr=8'h02.
- CHANNELS=5 build: reset bottom=4; specific EOI level 6 ignored; rotation wraps from 4 to 0.

Source files
------------

// File: rtl/irq_priority_resolver.sv
// irq_priority_resolver: rotating-priority resolver with a fully nested
// In-Service Register, acknowledge latching and EOI retirement.
module irq_priority_resolver #(
  parameter  int CHANNELS = 8,
  localparam int IDX_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irr,
  input  logic [CHANNELS-1:0] imr,
  input  logic                rotate_mode,
  input  logic                ack,
  input  logic                eoi,
  input  logic                eoi_specific,
  input  logic [IDX_W-1:0]    eoi_level,
  output logic                int_req,
  output logic [IDX_W-1:0]    ack_vec,
  output logic [CHANNELS-1:0] ack_onehot,
  output logic                spurious,
  output logic [CHANNELS-1:0] isr,
  output logic [IDX_W-1:0]    bottom
);

  logic [CHANNELS-1:0] cand;
  logic                win_valid;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic                top_found;
  logic [IDX_W-1:0]    top_idx;
  logic [IDX_W-1:0]    scan_idx;
  int                  scan_pos;

  logic                level_ok;
  logic [CHANNELS-1:0] eoi_clear;
  logic [CHANNELS-1:0] ack_set;
  logic [IDX_W-1:0]    bottom_next;

  // A specific EOI naming a channel that does not exist is dropped entirely.
  assign level_ok = ({1'b0, eoi_level} < (IDX_W + 1)'(CHANNELS));

  // Walk channels from highest to lowest priority. The first channel that is
  // either in service or a candidate decides nesting: a winner is valid only
  // if it is reached before any in-service channel.
  always_comb begin
    cand      = irr & ~imr & ~isr;
    win_found = 1'b0;
    win_valid = 1'b0;
    win_idx   = '0;
    top_found = 1'b0;
    top_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      scan_pos = int'(bottom) + 1 + k;
      if (scan_pos >= CHANNELS) scan_pos = scan_pos - CHANNELS;
      scan_idx = IDX_W'(scan_pos);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
        win_valid = !top_found;
      end
      if (!top_found && isr[scan_idx]) begin
        top_found = 1'b1;
        top_idx   = scan_idx;
      end
    end
  end

  // Work out which ISR bit an EOI retires and where the rotation point moves.
  always_comb begin
    eoi_clear   = '0;
    bottom_next = bottom;
    if (eoi) begin
      if (eoi_specific) begin
        if (level_ok) begin
          eoi_clear[eoi_level] = 1'b1;
          if (rotate_mode) bottom_next = eoi_level;
        end
      end else if (top_found) begin
        eoi_clear[top_idx] = 1'b1;
        if (rotate_mode) bottom_next = top_idx;
      end
    end
  end

  // An acknowledge with a valid winner marks exactly that channel in service.
  always_comb begin
    ack_set = '0;
    if (ack && win_valid) ack_set = CHANNELS'(1) << win_idx;
  end

  // State update: ISR merge (ack wins over EOI on the same bit), rotation,
  // registered request and the single-cycle acknowledge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isr        <= '0;
      bottom     <= IDX_W'(CHANNELS - 1);
      int_req    <= 1'b0;
      ack_vec    <= '0;
      ack_onehot <= '0;
      spurious   <= 1'b0;
    end else begin
      isr        <= (isr & ~eoi_clear) | ack_set;
      bottom     <= bottom_next;
      int_req    <= win_valid & ~ack;
      ack_onehot <= ack_set;
      spurious   <= ack & ~win_valid;
      if (ack) ack_vec <= win_valid ? win_idx : IDX_W'(CHANNELS - 1);
    end
  end

endmodule

// File: tb/tb_irq_priority_resolver.sv
// tb_irq_priority_resolver: drives an 8-channel and a 5-channel resolver with
// the same stimulus and checks both every cycle against a behavioural model.
module tb_irq_priority_resolver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr, imr;
  logic       rotate_mode, ack, eoi, eoi_specific;
  logic [2:0] eoi_level;

  logic       int_req8, spurious8;
  logic [2:0] ack_vec8, bottom8;
  logic [7:0] ack_onehot8, isr8;

  logic       int_req5, spurious5;
  logic [2:0] ack_vec5, bottom5;
  logic [4:0] ack_onehot5, isr5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] isr;
    int         bottom;
    logic       int_req;
    int         ack_vec;
    logic [7:0] onehot;
    logic       spur;
  } mstate_t;

  mstate_t m8, m5;

  irq_priority_resolver #(.CHANNELS(8)) dut8 (
    .clk(clk), .reset(reset), .irr(irr), .imr(imr),
    .rotate_mode(rotate_mode), .ack(ack), .eoi(eoi),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .int_req(int_req8), .ack_vec(ack_vec8), .ack_onehot(ack_onehot8),
    .spurious(spurious8), .isr(isr8), .bottom(bottom8)
  );

  irq_priority_resolver #(.CHANNELS(5)) dut5 (
    .clk(clk), .reset(reset), .irr(irr[4:0]), .imr(imr[4:0]),
    .rotate_mode(rotate_mode), .ack(ack), .eoi(eoi),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .int_req(int_req5), .ack_vec(ack_vec5), .ack_onehot(ack_onehot5),
    .spurious(spurious5), .isr(isr5), .bottom(bottom5)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Priority distance from the top: 0 is the highest-priority channel.
  function automatic int rankOf(input int ch, input int bot, input int n);
    return (ch - bot - 1 + 2 * n) % n;
  endfunction

  function automatic mstate_t resetState(input int n);
    mstate_t s;
    s.isr = '0; s.bottom = n - 1; s.int_req = 1'b0;
    s.ack_vec = 0; s.onehot = '0; s.spur = 1'b0;
    return s;
  endfunction

  // One clock of the resolver, described from the priority rules directly.
  function automatic mstate_t modelStep(input mstate_t s, input int n,
                                        input logic [7:0] r, input logic [7:0] m,
                                        input logic rot, input logic a,
                                        input logic e, input logic sp, input int lvl);
    mstate_t    nx;
    logic [7:0] c, clr, setb;
    int         best_c, best_h;
    logic       valid;
    nx = s;
    c = r & ~m & ~s.isr;
    best_c = -1;
    best_h = -1;
    for (int ch = 0; ch < n; ch++) begin
      if (c[ch] && (best_c < 0 || rankOf(ch, s.bottom, n) < rankOf(best_c, s.bottom, n)))
        best_c = ch;
      if (s.isr[ch] && (best_h < 0 || rankOf(ch, s.bottom, n) < rankOf(best_h, s.bottom, n)))
        best_h = ch;
    end
    valid = (best_c >= 0) &&
            (best_h < 0 || rankOf(best_c, s.bottom, n) < rankOf(best_h, s.bottom, n));
    clr = '0;
    setb = '0;
    if (e) begin
      if (!sp) begin
        if (best_h >= 0) begin
          clr[best_h] = 1'b1;
          if (rot) nx.bottom = best_h;
        end
      end else if (lvl < n) begin
        clr[lvl] = 1'b1;
        if (rot) nx.bottom = lvl;
      end
    end
    nx.onehot = '0;
    nx.spur = 1'b0;
    if (a) begin
      if (valid) begin
        setb[best_c] = 1'b1;
        nx.ack_vec = best_c;
        nx.onehot = setb;
      end else begin
        nx.spur = 1'b1;
        nx.ack_vec = n - 1;
      end
    end
    nx.isr = (s.isr & ~clr) | setb;
    nx.int_req = valid && !a;
    return nx;
  endfunction

  // Reference model advances on the same edges as the designs
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m8 = resetState(8);
      m5 = resetState(5);
    end else begin
      m8 = modelStep(m8, 8, irr, imr, rotate_mode, ack, eoi, eoi_specific, int'(eoi_level));
      m5 = modelStep(m5, 5, irr & 8'h1f, imr & 8'h1f, rotate_mode, ack, eoi,
                     eoi_specific, int'(eoi_level));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("int_req8",   32'(int_req8),    32'(m8.int_req));
    checkOutput("ack_vec8",   32'(ack_vec8),    32'(m8.ack_vec));
    checkOutput("onehot8",    32'(ack_onehot8), 32'(m8.onehot));
    checkOutput("spurious8",  32'(spurious8),   32'(m8.spur));
    checkOutput("isr8",       32'(isr8),        32'(m8.isr));
    checkOutput("bottom8",    32'(bottom8),     32'(m8.bottom));
    checkOutput("int_req5",   32'(int_req5),    32'(m5.int_req));
    checkOutput("ack_vec5",   32'(ack_vec5),    32'(m5.ack_vec));
    checkOutput("onehot5",    32'(ack_onehot5), 32'(m5.onehot[4:0]));
    checkOutput("spurious5",  32'(spurious5),   32'(m5.spur));
    checkOutput("isr5",       32'(isr5),        32'(m5.isr[4:0]));
    checkOutput("bottom5",    32'(bottom5),     32'(m5.bottom));
  endtask

  task automatic applyStimulus(input logic [7:0] i_irr, input logic [7:0] i_imr,
                               input logic i_rot, input logic i_ack, input logic i_eoi,
                               input logic i_spec, input logic [2:0] i_lvl);
    irr = i_irr; imr = i_imr; rotate_mode = i_rot; ack = i_ack;
    eoi = i_eoi; eoi_specific = i_spec; eoi_level = i_lvl;
  endtask

  task automatic tick();
    @(negedge clk);
    compareModel();
  endtask

  // Directed sequence with hand-computed values, then randomized traffic
  initial begin
    reset = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    tick();
    checkOutput("rst int_req", 32'(int_req8), 32'd0);
    checkOutput("rst bottom8", 32'(bottom8), 32'd7);
    checkOutput("rst isr", 32'(isr8), 32'd0);
    checkOutput("rst ack_vec", 32'(ack_vec8), 32'd0);
    checkOutput("rst onehot", 32'(ack_onehot8), 32'd0);
    checkOutput("rst spurious", 32'(spurious8), 32'd0);
    checkOutput("rst bottom5", 32'(bottom5), 32'd4);
    reset = 1'b0;

    applyStimulus(8'h24, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("req raise", 32'(int_req8), 32'd1);
    applyStimulus(8'h24, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("ack vec", 32'(ack_vec8), 32'd2);
    checkOutput("ack onehot", 32'(ack_onehot8), 32'h04);
    checkOutput("ack isr", 32'(isr8), 32'h04);
    checkOutput("ack drops req", 32'(int_req8), 32'd0);
    applyStimulus(8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("lower blocked", 32'(int_req8), 32'd0);
    checkOutput("onehot pulse", 32'(ack_onehot8), 32'd0);
    applyStimulus(8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("nest req", 32'(int_req8), 32'd1);
    applyStimulus(8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("only bit5", 32'(int_req8), 32'd0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("spur flag", 32'(spurious8), 32'd1);
    checkOutput("spur vec", 32'(ack_vec8), 32'd7);
    checkOutput("spur isr", 32'(isr8), 32'h04);
    checkOutput("spur onehot", 32'(ack_onehot8), 32'd0);
    checkOutput("spur vec5", 32'(ack_vec5), 32'd4);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2); tick();
    checkOutput("spec eoi isr", 32'(isr8), 32'd0);
    checkOutput("no rotate", 32'(bottom8), 32'd7);
    checkOutput("spur pulse", 32'(spurious8), 32'd0);
    applyStimulus(8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("req ch3", 32'(int_req8), 32'd1);
    applyStimulus(8'h08, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("isr ch3", 32'(isr8), 32'h08);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0); tick();
    checkOutput("ns eoi isr", 32'(isr8), 32'd0);
    checkOutput("ns rotate", 32'(bottom8), 32'd3);
    checkOutput("ns rotate5", 32'(bottom5), 32'd3);
    applyStimulus(8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("rot req", 32'(int_req8), 32'd1);
    applyStimulus(8'h81, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("rot vec", 32'(ack_vec8), 32'd7);
    checkOutput("rot onehot", 32'(ack_onehot8), 32'h80);
    checkOutput("rot vec5", 32'(ack_vec5), 32'd0);
    checkOutput("rot isr5", 32'(isr5), 32'h01);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7); tick();
    checkOutput("lvl7 isr8", 32'(isr8), 32'd0);
    checkOutput("lvl7 bottom8", 32'(bottom8), 32'd7);
    checkOutput("lvl7 ignored isr5", 32'(isr5), 32'h01);
    checkOutput("lvl7 ignored bot5", 32'(bottom5), 32'd3);
    applyStimulus(8'h08, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0); tick();
    checkOutput("pre same isr", 32'(isr8), 32'h08);
    applyStimulus(8'h02, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3); tick();
    checkOutput("same cycle isr", 32'(isr8), 32'h02);
    checkOutput("same cycle vec", 32'(ack_vec8), 32'd1);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tick();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [7:0] r_irr;
      logic       r_rot;
      r_irr = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      r_rot = ($urandom_range(0, 15) == 0) ? ~rotate_mode : rotate_mode;
      applyStimulus(r_irr, 8'($urandom & $urandom & $urandom), r_rot,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    1'($urandom), 3'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
